// File: rtl/race_game_ctrl.sv
// race_game_ctrl: lives/score/crash FSM driving the movers, collision detector clear and the HUD.
// Optional RACE_HISCORE_EN adds a persistent hi_score output.
module race_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int CRASH_FRAMES = 90,
  parameter int SCORE_FRAMES = 60,
  parameter int SCORE_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               collision,
  output logic               collision_clr,
  output logic               run_en,
  output logic [1:0]         state,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               crash_flash,
`ifdef RACE_HISCORE_EN
  output logic [SCORE_W-1:0] hi_score,
`endif
  output logic               game_over
);
  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, CRASH = 2'd2, OVER = 2'd3;
  localparam int FW = SCORE_FRAMES > 1 ? $clog2(SCORE_FRAMES) : 1;
  localparam int CW = CRASH_FRAMES > 1 ? $clog2(CRASH_FRAMES) : 1;
  logic [1:0]         state_q, state_d;
  logic [2:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic [CW-1:0]      crash_q, crash_d, crash_inc;
  logic               flash_q, flash_d, start_prev_q, start_rise;
  logic               run_q, clr_q, over_q;
  assign start_rise = start_btn & ~start_prev_q;
  assign crash_inc  = crash_q + 1'b1;
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    frame_d = frame_q;
    crash_d = crash_q;
    flash_d = flash_q;
    case (state_q)
      PLAY:
        if (collision) begin
          state_d = CRASH;
          lives_d = lives_q - {2'b00, |lives_q};
          crash_d = '0;
        end else if (frame_tick) begin
          frame_d = frame_q == FW'(SCORE_FRAMES - 1) ? '0 : frame_q + 1'b1;
          score_d = (frame_q == FW'(SCORE_FRAMES - 1) && !(&score_q)) ? score_q + 1'b1 : score_q;
        end
      CRASH:
        if (frame_tick) begin
          // the tick that finds the counter at its last value ends the freeze
          if (crash_q == CW'(CRASH_FRAMES - 1)) begin
            state_d = lives_q == 3'd0 ? OVER : PLAY;
            frame_d = '0;
            flash_d = 1'b0;
          end else begin
            crash_d = crash_inc;
            flash_d = |(crash_inc & CW'(8));
          end
        end
      default:
        if (start_rise) begin
          state_d = PLAY;
          lives_d = 3'(LIVES);
          score_d = '0;
          frame_d = '0;
        end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lives_q      <= 3'(LIVES);
      score_q      <= '0;
      frame_q      <= '0;
      crash_q      <= '0;
      flash_q      <= 1'b0;
      start_prev_q <= 1'b0;
      run_q        <= 1'b0;
      clr_q        <= 1'b1;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      frame_q      <= frame_d;
      crash_q      <= crash_d;
      flash_q      <= flash_d;
      start_prev_q <= start_btn;
      run_q        <= state_d == PLAY;
      clr_q        <= state_d != PLAY;
      over_q       <= state_d == OVER;
    end
  end
`ifdef RACE_HISCORE_EN
  logic [SCORE_W-1:0] hi_q;
  always_ff @(posedge clk) begin
    if (reset) hi_q <= '0;
    else if (state_d == OVER && state_q != OVER && score_q > hi_q) hi_q <= score_q;
  end
  assign hi_score = hi_q;
`endif
  assign state         = state_q;
  assign lives         = lives_q;
  assign score         = score_q;
  assign crash_flash   = flash_q;
  assign run_en        = run_q;
  assign collision_clr = clr_q;
  assign game_over     = over_q;
endmodule

// File: tb/tb_race_game_ctrl.sv
// tb_race_game_ctrl: directed test of race_game_ctrl with small parameters (3 lives, 10-frame crash, 3 frames per point, 4-bit score).
module tb_race_game_ctrl;
  logic       clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, start_btn = 1'b0, collision = 1'b0;
  logic       collision_clr, run_en, crash_flash, game_over;
  logic [1:0] state;
  logic [2:0] lives;
  logic [3:0] score;
`ifdef RACE_HISCORE_EN
  logic [3:0] hi_score;
`endif
  int errors = 0, checks = 0;
  race_game_ctrl #(.LIVES(3), .CRASH_FRAMES(10), .SCORE_FRAMES(3), .SCORE_W(4)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn), .collision(collision),
    .collision_clr(collision_clr), .run_en(run_en), .state(state), .lives(lives), .score(score),
    .crash_flash(crash_flash),
`ifdef RACE_HISCORE_EN
    .hi_score(hi_score),
`endif
    .game_over(game_over));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic crash_once();
    collision = 1'b1;
    step();
    collision = 1'b0;
    tick(10);
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_clr", collision_clr, 1);
    chk("rst_run", run_en, 0);
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 0);
    chk("rst_flash", crash_flash, 0);
    chk("rst_over", game_over, 0);
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    chk("start_state", state, 1);
    chk("start_run", run_en, 1);
    chk("start_clr", collision_clr, 0);
    chk("start_lives", lives, 3);
    chk("start_score", score, 0);
    tick(7);
    chk("score_7ticks", score, 2);
    tick(1);
    collision = 1'b1;
    frame_tick = 1'b1;
    step();
    collision = 1'b0;
    frame_tick = 1'b0;
    chk("hit_state", state, 2);
    chk("hit_lives", lives, 2);
    chk("hit_score", score, 2);
    chk("hit_run", run_en, 0);
    chk("hit_clr", collision_clr, 1);
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    chk("crash_ignore_start", state, 2);
    collision = 1'b1;
    step();
    collision = 1'b0;
    chk("crash_ignore_hit", lives, 2);
    tick(7);
    chk("flash_off_7", crash_flash, 0);
    chk("crash_hold_7", state, 2);
    tick(1);
    chk("flash_on_8", crash_flash, 1);
    tick(1);
    chk("flash_on_9", crash_flash, 1);
    tick(1);
    chk("resume_state", state, 1);
    chk("resume_flash", crash_flash, 0);
    chk("resume_run", run_en, 1);
    chk("resume_clr", collision_clr, 0);
    chk("resume_score", score, 2);
    tick(2);
    chk("frame_restart", score, 2);
    tick(1);
    chk("score_after_resume", score, 3);
    tick(36);
    chk("score_max", score, 15);
    tick(6);
    chk("score_saturate", score, 15);
    collision = 1'b1;
    step();
    collision = 1'b0;
    chk("hit2_lives", lives, 1);
    tick(10);
    chk("hit2_resume", state, 1);
    crash_once();
    chk("over_state", state, 3);
    chk("over_flag", game_over, 1);
    chk("over_lives", lives, 0);
    chk("over_score", score, 15);
    chk("over_run", run_en, 0);
    chk("over_clr", collision_clr, 1);
    collision = 1'b1;
    tick(3);
    collision = 1'b0;
    chk("over_ignore_hit_state", state, 3);
    chk("over_ignore_hit_lives", lives, 0);
    chk("over_hold_score", score, 15);
`ifdef RACE_HISCORE_EN
    chk("hi_first", hi_score, 15);
`endif
    start_btn = 1'b1;
    step();
    chk("restart_state", state, 1);
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);
    chk("restart_over", game_over, 0);
    collision = 1'b1;
    step();
    collision = 1'b0;
    chk("pre_reset_crash", state, 2);
    reset = 1'b1;
    step();
    chk("midreset_state", state, 0);
    chk("midreset_lives", lives, 3);
    chk("midreset_score", score, 0);
    chk("midreset_clr", collision_clr, 1);
    step();
    reset = 1'b0;
    step();
    chk("held_start_play", state, 1);
    crash_once();
    crash_once();
    crash_once();
    step();
    step();
    chk("held_start_no_retrigger", state, 3);
`ifdef RACE_HISCORE_EN
    chk("hi_after_reset", hi_score, 0);
`endif
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    chk("new_rise_play", state, 1);
    chk("new_rise_lives", lives, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
